uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Round-robin scheduler and framer that shares one UART transmit line among `NUM_REQ` byte requesters.
- It arbitrates pending requests, latches the winner's byte, and serialises it as an 8N1 frame.
- All bit boundaries are paced by the single-cycle tick from the TX baud generator.
- It sits between the per-client byte sources and the `tx` pad, downstream of the baud tick generator.

## Interface
Reset is one clock domain with an asynchronous, active-low reset.

Parameters:
- `NUM_REQ`, 4: number of requesters; legal range ≥2.
- `DATA_W`, 8: bits per character. The frame is fixed as 1 start bit, `DATA_W` data bits LSB first, 1 stop bit.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-low reset.
- `baud_tick` input 1: one-`clk` pulse per bit period, from the baud generator.
- `req` input `NUM_REQ`: per-client request. The client holds it high until its `ack`.
- `data` input `NUM_REQ*DATA_W`: flattened bytes. Client i owns `data[i*DATA_W +: DATA_W]`, which must be stable while `req[i]` is high.
- `ack` output `NUM_REQ`: one-hot, one-cycle pulse when the client's byte is latched.
- `tx` output 1: serial line, idle high.
- `busy` output 1: high whenever the state is not IDLE.
- `owner` output `$clog2(NUM_REQ)`: index of the client whose frame is in flight; holds its last value when idle.
- `done` output 1: one-cycle pulse at the end of the stop bit.

## Operation
FSM states are IDLE, ARM, START, DATA and STOP. All outputs are registered.

IDLE:
- If `req != 0`, grant the first set bit searching from `ptr`, `ptr+1`, … with wrap modulo `NUM_REQ`.
- On grant: latch that client's byte into `shreg`, pulse `ack[winner]`, set `owner` to the winner, set `ptr` to `(winner+1) mod NUM_REQ`, then go to ARM.
- `baud_tick` is ignored in IDLE.

ARM: on `baud_tick`, `tx` goes to 0 (start bit) and the state moves to START.

START: on `baud_tick`, `tx` takes `shreg[0]`, `shreg` shifts right, `bit_cnt` is set to 0, and the state moves to DATA.

DATA: on `baud_tick`:
- If `bit_cnt == DATA_W-1`: `tx` goes to 1 (stop bit) and the state moves to STOP.
- Otherwise: `tx` takes the next LSB and `bit_cnt` increments.

STOP: on `baud_tick`, pulse `done` and return to IDLE. `tx` stays 1.

Rules:
- Arbitration happens only in IDLE. Requests that arrive mid-frame wait.
- `req` dropped before `ack` means the client is not served. No error is flagged.
- `ptr` resets to 0. A lone requester is served back-to-back.
- `bit_cnt` is `$clog2(DATA_W)` bits wide and never exceeds `DATA_W-1`.

## Timing
Reset values (applied asynchronously while `rst`=0, regardless of state):
- `tx`=1, `ack`=0, `busy`=0, `done`=0, `owner`=0.
- State=IDLE, `ptr`=0, `shreg`=0, `bit_cnt`=0.
- A frame interrupted by reset is abandoned; the line returns high immediately.

Request to acknowledge:
- `req` high in IDLE gives `ack` on the next `clk` edge (1-cycle latency).
- `busy` rises on that same edge.

Bit timing:
- The start bit begins on the first `baud_tick` after ARM is entered. Bit width is therefore the first tick period after the grant, not a partial one.
- Every bit, including the stop bit, lasts exactly one tick-to-tick interval.
- `tx` changes in the cycle after the tick edge.

End of frame:
- `done` and the IDLE transition occur on the same edge. `busy` falls on that edge.
- A pending request is granted on the next edge. The next start bit waits for the following tick, so the stop bit is never shortened.

Simultaneous events:
- Several `req` bits in the same cycle: only the round-robin winner gets `ack`.
- `baud_tick` coinciding with the grant cycle is ignored.
- Frame length is `DATA_W+2` ticks from start-bit edge to `done`.

## Test plan
- **Reset:** hold `rst`=0 mid-DATA. Required: `tx`=1, `busy`=0, `ack`=0 within the same cycle. After release, `req`=0001 gives `ack`=0001 one cycle later.
- **Single frame:** tick every 4 clks, `req[0]` with byte 0x55. Required: `tx` sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 clks wide. `done` pulses 10 ticks after the start edge, then `busy`=0.
- **Round-robin:** `req`=1111 held, bytes 0xA0..0xA3. Required: `ack` order 0001, 0010, 0100, 1000, 0001, with `owner` 0,1,2,3,0. Serial bytes arrive in the same order.
- **Skip:** `ptr`=1 and `req`=1001. Required: client 3 granted first, then client 0.
- **Back-to-back:** client 2 alone, bytes 0xFF then 0x00. Required: stop bit exactly one tick period. Second start bit on the first tick after the second `ack`.
- **Mid-frame arrival and withdrawal:** `req[1]` rises during DATA. Required: no `ack` until IDLE. Separately, `req[2]` pulsed and dropped while busy. Required: never acknowledged, no frame sent.

Source files
------------

// File: rtl/uart_tx_sched.sv
`timescale 1ns/1ps
// uart_tx_sched
//
// Shares one UART transmit line among NUM_REQ byte requesters. Pending
// requests are arbitrated round-robin while the line is idle. The winning
// byte is latched and sent as an 8N1-style frame: one start bit, DATA_W data
// bits LSB first, and one stop bit. Every bit boundary is paced by baud_tick.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-low reset
//   baud_tick  one-clk pulse per bit period
//   req        per-client request, held high until that client's ack
//   data       flattened bytes; client i owns data[i*DATA_W +: DATA_W]
//   ack        one-hot, one-cycle pulse when a client's byte is latched
//   tx         serial line, idles high
//   busy       high whenever a frame is being handled (state != IDLE)
//   owner      index of the client whose frame is in flight (held when idle)
//   done       one-cycle pulse at the end of the stop bit
module uart_tx_sched #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         baud_tick,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_W-1:0]    data,
    output logic [NUM_REQ-1:0]           ack,
    output logic                         tx,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   owner,
    output logic                         done
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        DATA,
        STOP
    } state_t;

    state_t              state_q,   state_d;
    logic [IDX_W-1:0]    ptr_q,     ptr_d;
    logic [DATA_W-1:0]   shreg_q,   shreg_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                tx_q,      tx_d;
    logic [NUM_REQ-1:0]  ack_q,     ack_d;
    logic [IDX_W-1:0]    owner_q,   owner_d;
    logic                done_q,    done_d;
    logic                busy_q,    busy_d;

    logic                grant_vld;
    logic [IDX_W-1:0]    grant_idx;
    logic [IDX_W-1:0]    cand;
    logic [IDX_W-1:0]    ptr_next;

    // Index base+offs wrapped modulo NUM_REQ; offs is always < NUM_REQ.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDX_W'(sum);
    endfunction

    // Round-robin search: first set request at ptr, ptr+1, ... with wrap.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_idx(ptr_q, k);
            if (!grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign ptr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);

    // Next-state and registered-output values.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        owner_d   = owner_q;
        ack_d     = '0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // baud_tick is deliberately ignored here so the start bit
                // always gets a full tick period after the grant.
                if (grant_vld) begin
                    shreg_d          = data[int'(grant_idx)*DATA_W +: DATA_W];
                    ack_d[grant_idx] = 1'b1;
                    owner_d          = grant_idx;
                    ptr_d            = ptr_next;
                    state_d          = ARM;
                end
            end
            ARM: begin
                if (baud_tick) begin
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    tx_d      = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        tx_d      = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    tx_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            ack_q     <= '0;
            owner_q   <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            ack_q     <= ack_d;
            owner_q   <= owner_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign tx    = tx_q;
    assign ack   = ack_q;
    assign owner = owner_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
`timescale 1ns/1ps
// tb_uart_tx_sched
//
// Directed bench for uart_tx_sched with NUM_REQ=4, DATA_W=8 and a baud tick
// every 4 clocks (ticks land on edges whose cycle number is a multiple of 4).
// Every clock edge is recorded (tx, busy, ack, done) so frames can be decoded
// afterwards and compared with hand-computed bytes and cycle positions.
module tb_uart_tx_sched;

    localparam int NUM_REQ  = 4;
    localparam int DATA_W   = 8;
    localparam int TICK_DIV = 4;
    localparam int HIST_N   = 4096;
    localparam int LOG_N    = 16;
    localparam int FRAME_C  = (DATA_W + 2) * TICK_DIV;

    logic                       clk;
    logic                       rst;
    logic                       baud_tick;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*DATA_W-1:0]  data;
    logic [NUM_REQ-1:0]         ack;
    logic                       tx;
    logic                       busy;
    logic [1:0]                 owner;
    logic                       done;

    uart_tx_sched #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .req       (req),
        .data      (data),
        .ack       (ack),
        .tx        (tx),
        .busy      (busy),
        .owner     (owner),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int                 tests_run;
    int                 tests_failed;
    int                 cyc;
    logic               tx_hist [HIST_N];
    int                 ack_n;
    int                 done_n;
    logic [NUM_REQ-1:0] ack_log [LOG_N];
    logic [1:0]         own_log [LOG_N];
    int                 ack_cyc [LOG_N];
    int                 done_cyc [LOG_N];
    bit                 drop_on_ack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge; sample #1 after it, log events, set tick for next edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc < HIST_N) tx_hist[cyc] = tx;
        if (ack != '0 && ack_n < LOG_N) begin
            ack_log[ack_n] = ack;
            own_log[ack_n] = owner;
            ack_cyc[ack_n] = cyc;
            ack_n++;
            if (drop_on_ack) req = req & ~ack;
        end
        if (done === 1'b1 && done_n < LOG_N) begin
            done_cyc[done_n] = cyc;
            done_n++;
        end
        baud_tick = ((cyc + 1) % TICK_DIV == 0);
    endtask

    task automatic clear_logs();
        ack_n  = 0;
        done_n = 0;
        for (int i = 0; i < LOG_N; i++) begin
            ack_log[i]  = '0;
            own_log[i]  = '0;
            ack_cyc[i]  = -1;
            done_cyc[i] = -1;
        end
    endtask

    task automatic wait_acks(input int n, input int limit);
        int k;
        k = 0;
        while (ack_n < n && k < limit) begin
            step();
            k++;
        end
        chk($sformatf("ack_count_reached_%0d", n), 32'(ack_n >= n), 32'd1);
    endtask

    task automatic wait_dones(input int n, input int limit);
        int k;
        k = 0;
        while (done_n < n && k < limit) begin
            step();
            k++;
        end
        chk($sformatf("done_count_reached_%0d", n), 32'(done_n >= n), 32'd1);
    endtask

    // Idle high before t0, start low, every bit constant for a full tick
    // period, stop bit high.
    function automatic bit shape_ok(input int t0);
        if (t0 < 1 || t0 + FRAME_C >= HIST_N) return 1'b0;
        if (tx_hist[t0-1] !== 1'b1) return 1'b0;
        if (tx_hist[t0] !== 1'b0) return 1'b0;
        if (tx_hist[t0 + (DATA_W+1)*TICK_DIV] !== 1'b1) return 1'b0;
        for (int b = 0; b < DATA_W + 2; b++) begin
            for (int s = 1; s < TICK_DIV; s++) begin
                if (tx_hist[t0 + b*TICK_DIV + s] !== tx_hist[t0 + b*TICK_DIV]) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [7:0] frame_byte(input int t0);
        logic [7:0] v;
        v = 'x;
        if (t0 >= 1 && t0 + FRAME_C < HIST_N) begin
            for (int k = 0; k < DATA_W; k++) v[k] = tx_hist[t0 + (k+1)*TICK_DIV];
        end
        return v;
    endfunction

    // Frame k must start on the first tick strictly after its ack edge and
    // raise done exactly DATA_W+2 ticks after that start edge.
    task automatic check_frame(input int k, input logic [7:0] exp_byte);
        int t0;
        t0 = (ack_cyc[k] / TICK_DIV + 1) * TICK_DIV;
        chk($sformatf("frame%0d_shape", k), 32'(shape_ok(t0)), 32'd1);
        chk($sformatf("frame%0d_byte", k), 32'(frame_byte(t0)), 32'(exp_byte));
        chk($sformatf("frame%0d_done_cycle", k), 32'(done_cyc[k]), 32'(t0 + FRAME_C));
    endtask

    initial begin
        int  t0;
        int  c0;
        bit  idle_ok;

        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        rst          = 1'b0;
        req          = '0;
        data         = '0;
        baud_tick    = 1'b0;
        drop_on_ack  = 1'b0;
        for (int i = 0; i < HIST_N; i++) tx_hist[i] = 1'b1;
        clear_logs();

        // ---- Reset state ----
        repeat (3) step();
        chk("reset_tx",    32'(tx),    32'd1);
        chk("reset_ack",   32'(ack),   32'd0);
        chk("reset_busy",  32'(busy),  32'd0);
        chk("reset_done",  32'(done),  32'd0);
        chk("reset_owner", 32'(owner), 32'd0);
        rst = 1'b1;
        repeat (2) step();

        // ---- Round-robin: all four held, ptr starts at 0 ----
        clear_logs();
        data        = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        drop_on_ack = 1'b0;
        req         = 4'b1111;
        wait_acks(5, 400);
        req = '0;
        wait_dones(5, 100);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr_ack%0d", k),   32'(ack_log[k]), 32'(1 << (k % 4)));
            chk($sformatf("rr_owner%0d", k), 32'(own_log[k]), 32'(k % 4));
            check_frame(k, 8'(32'hA0 + k % 4));
            if (k > 0) chk($sformatf("rr_regrant%0d", k), 32'(ack_cyc[k]), 32'(done_cyc[k-1] + 1));
        end

        // ---- Skip: ptr=1, req=1001 -> client 3 then client 0 ----
        clear_logs();
        drop_on_ack = 1'b1;
        req         = 4'b1001;
        wait_dones(2, 200);
        chk("skip_ack0",   32'(ack_log[0]), 32'(4'b1000));
        chk("skip_owner0", 32'(own_log[0]), 32'd3);
        chk("skip_ack1",   32'(ack_log[1]), 32'(4'b0001));
        chk("skip_owner1", 32'(own_log[1]), 32'd0);
        check_frame(0, 8'hA3);
        check_frame(1, 8'hA0);

        // ---- Single frame 0x55 from client 0 ----
        clear_logs();
        data[7:0] = 8'h55;
        req       = 4'b0001;
        c0        = cyc;
        step();
        chk("single_ack",       32'(ack),   32'(4'b0001));
        chk("single_busy_rise", 32'(busy),  32'd1);
        chk("single_owner",     32'(owner), 32'd0);
        chk("single_ack_cycle", 32'(ack_cyc[0]), 32'(c0 + 1));
        wait_dones(1, 100);
        chk("single_busy_fall", 32'(busy), 32'd0);
        check_frame(0, 8'h55);
        step();
        chk("single_done_width", 32'(done), 32'd0);

        // ---- Back-to-back: client 2 alone, 0xFF then 0x00 ----
        clear_logs();
        drop_on_ack  = 1'b0;
        data[23:16]  = 8'hFF;
        req          = 4'b0100;
        wait_acks(1, 10);
        data[23:16]  = 8'h00;
        wait_acks(2, 100);
        req = '0;
        wait_dones(2, 100);
        chk("b2b_ack0",    32'(ack_log[0]), 32'(4'b0100));
        chk("b2b_ack1",    32'(ack_log[1]), 32'(4'b0100));
        chk("b2b_owner1",  32'(own_log[1]), 32'd2);
        chk("b2b_regrant", 32'(ack_cyc[1]), 32'(done_cyc[0] + 1));
        check_frame(0, 8'hFF);
        check_frame(1, 8'h00);

        // ---- Mid-frame arrival (client 1) and withdrawal (client 2) ----
        clear_logs();
        drop_on_ack  = 1'b1;
        data[7:0]    = 8'h81;
        data[15:8]   = 8'h96;
        data[23:16]  = 8'h5A;
        req          = 4'b0001;
        wait_acks(1, 10);
        repeat (12) step();
        req[1] = 1'b1;
        repeat (2) step();
        req[2] = 1'b1;
        repeat (3) step();
        req[2] = 1'b0;
        wait_dones(2, 150);
        repeat (30) step();
        chk("mid_ack_count", 32'(ack_n),      32'd2);
        chk("mid_ack1",      32'(ack_log[1]), 32'(4'b0010));
        chk("mid_owner1",    32'(own_log[1]), 32'd1);
        chk("mid_wait_idle", 32'(ack_cyc[1]), 32'(done_cyc[0] + 1));
        check_frame(0, 8'h81);
        check_frame(1, 8'h96);
        idle_ok = 1'b1;
        for (int c = done_cyc[1]; c <= cyc && c < HIST_N; c++) begin
            if (c >= 0 && tx_hist[c] !== 1'b1) idle_ok = 1'b0;
        end
        chk("withdrawn_no_frame", 32'(idle_ok), 32'd1);
        chk("mid_done_count", 32'(done_n), 32'd2);

        // ---- Reset mid-DATA, then ptr must be back at 0 ----
        clear_logs();
        drop_on_ack = 1'b1;
        data[7:0]   = 8'h3C;
        req         = 4'b0001;
        wait_acks(1, 10);
        t0 = (ack_cyc[0] / TICK_DIV + 1) * TICK_DIV;
        while (cyc < t0 + 2*TICK_DIV) step();
        chk("pre_reset_tx",   32'(tx),   32'd0);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("async_reset_tx",   32'(tx),   32'd1);
        chk("async_reset_busy", 32'(busy), 32'd0);
        chk("async_reset_ack",  32'(ack),  32'd0);
        chk("async_reset_done", 32'(done), 32'd0);
        step();
        step();
        rst = 1'b1;
        clear_logs();
        req = 4'b0011;
        step();
        chk("post_reset_ack",   32'(ack),   32'(4'b0001));
        chk("post_reset_owner", 32'(owner), 32'd0);
        chk("post_reset_busy",  32'(busy),  32'd1);
        wait_dones(2, 150);
        chk("post_reset_ack1", 32'(ack_log[1]), 32'(4'b0010));
        check_frame(0, 8'h3C);
        check_frame(1, 8'h96);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
